sched_partial_dispatcher: RTL and testbench

Controller that sequences one partial-scheduler instance (8 running-task slots, W-bit slot words, W-1-bit task words).
- Buffers incoming tasks in a local FIFO and issues them one at a time with the wr / busy_ready handshake.
- Re-issues a task the scheduler flags as still active, and forwards exchanged (evicted) tasks to a downstream port.
- Generates the periodic subtract_en tick that ages running tasks.

---
 rtl/sched_partial_dispatcher.sv | 205 ++++++++++++++++++++
 tb/tb_sched_partial_dispatcher.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sched_partial_dispatcher.sv
// Dispatcher for one partial-scheduler instance: input FIFO, issue/retry/evict FSM, aging tick.
// Optional: define DISPATCH_STATS_EN to add saturating issue/retry/evict counters.
module sched_partial_dispatcher #(
  parameter int unsigned W           = 59,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TICK_PERIOD = 16,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     cfg_action,
  input  logic                     in_valid,
  input  logic [W-2:0]             in_task,
  output logic                     in_ready,
  output logic                     sch_wr,
  output logic [W-2:0]             sch_task,
  output logic                     sch_action,
  output logic                     sch_subtract_en,
  input  logic                     sch_busy_ready,
  input  logic                     sch_v_exch,
  input  logic                     sch_v_active,
  input  logic [W-2:0]             sch_task_exch,
  output logic                     evict_valid,
  output logic [W-2:0]             evict_task,
  output logic                     evict_err,
  input  logic                     evict_ready,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef DISPATCH_STATS_EN
  ,
  output logic [15:0]              stat_issued,
  output logic [15:0]              stat_retry,
  output logic [15:0]              stat_evict
`endif
);

  localparam int unsigned TW  = W - 1;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned TCW = $clog2(TICK_PERIOD);
  localparam int unsigned RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    EVICT   = 3'd4
  } state_t;

  state_t          state;
  logic [1:0]      wait_cnt;
  logic [RW-1:0]   retry_cnt;

  logic [TW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_nxt;

  logic [TCW-1:0]  tick_cnt;
  logic            tick_pending;

  logic            push;
  logic            pop;
  logic            result_c;
  logic            retry_ok;
  logic            go_issue;
  logic            tick_fire;

  assign sch_action = cfg_action;

  // Decisions shared by the FSM, the FIFO and the tick scheduler.
  always_comb begin
    push      = in_valid && in_ready;
    pop       = (state == IDLE) && en && (fifo_count != '0);
    result_c  = (state == WAIT_LO) && !sch_busy_ready;
    retry_ok  = retry_cnt < RW'(MAX_RETRY);
    go_issue  = pop || (result_c && sch_v_exch && sch_v_active && retry_ok);
    tick_fire = tick_pending && !go_issue;
    count_nxt = fifo_count;
    case ({push, pop})
      2'b10:   count_nxt = fifo_count + CW'(1);
      2'b01:   count_nxt = fifo_count - CW'(1);
      default: count_nxt = fifo_count;
    endcase
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_task;
  end

  // FIFO pointers and occupancy; DEPTH is a power of 2 so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      in_ready   <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_nxt;
      in_ready   <= (count_nxt != CW'(DEPTH));
    end
  end

  // Issue / retry / evict sequencer; sch_task doubles as the hold register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      retry_cnt   <= '0;
      sch_wr      <= 1'b0;
      sch_task    <= '0;
      evict_valid <= 1'b0;
      evict_task  <= '0;
      evict_err   <= 1'b0;
    end else begin
      sch_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            sch_task  <= mem[rd_ptr];
            sch_wr    <= 1'b1;
            retry_cnt <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT_HI;
        end
        WAIT_HI: begin
          // A scheduler that never raises busy is treated as already done.
          if (sch_busy_ready || (wait_cnt == 2'd3)) state <= WAIT_LO;
          else wait_cnt <= wait_cnt + 2'd1;
        end
        WAIT_LO: begin
          if (!sch_busy_ready) begin
            if (sch_v_exch && sch_v_active) begin
              if (retry_ok) begin
                retry_cnt <= retry_cnt + RW'(1);
                sch_wr    <= 1'b1;
                state     <= ISSUE;
              end else begin
                evict_valid <= 1'b1;
                evict_task  <= sch_task;
                evict_err   <= 1'b1;
                state       <= EVICT;
              end
            end else if (sch_v_exch) begin
              evict_valid <= 1'b1;
              evict_task  <= sch_task_exch;
              evict_err   <= 1'b0;
              state       <= EVICT;
            end else begin
              state <= IDLE;
            end
          end
        end
        EVICT: begin
          if (evict_ready) begin
            evict_valid <= 1'b0;
            evict_err   <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Aging tick: one pending at most, held off for the cycle sch_wr is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt        <= '0;
      tick_pending    <= 1'b0;
      sch_subtract_en <= 1'b0;
    end else begin
      tick_cnt        <= (tick_cnt == TCW'(TICK_PERIOD - 1)) ? '0 : tick_cnt + TCW'(1);
      sch_subtract_en <= tick_fire;
      if (tick_cnt == TCW'(TICK_PERIOD - 1)) tick_pending <= 1'b1;
      else if (tick_fire)                    tick_pending <= 1'b0;
    end
  end

`ifdef DISPATCH_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued <= '0;
      stat_retry  <= '0;
      stat_evict  <= '0;
    end else begin
      if ((state == ISSUE) && (stat_issued != 16'hFFFF)) stat_issued <= stat_issued + 16'd1;
      if (result_c && sch_v_exch && sch_v_active && retry_ok && (stat_retry != 16'hFFFF))
        stat_retry <= stat_retry + 16'd1;
      if ((state == EVICT) && evict_ready && (stat_evict != 16'hFFFF))
        stat_evict <= stat_evict + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sched_partial_dispatcher.sv
// Directed bench for sched_partial_dispatcher: vector table plus multi-cycle corner sequences.
module tb_sched_partial_dispatcher;

  localparam int unsigned W     = 59;
  localparam int unsigned TW    = W - 1;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          cfg_action;
  logic          in_valid;
  logic [TW-1:0] in_task;
  logic          in_ready;
  logic          sch_wr;
  logic [TW-1:0] sch_task;
  logic          sch_action;
  logic          sch_subtract_en;
  logic          sch_busy_ready;
  logic          sch_v_exch;
  logic          sch_v_active;
  logic [TW-1:0] sch_task_exch;
  logic          evict_valid;
  logic [TW-1:0] evict_task;
  logic          evict_err;
  logic          evict_ready;
  logic [CW-1:0] fifo_count;
`ifdef DISPATCH_STATS_EN
  logic [15:0]   stat_issued;
  logic [15:0]   stat_retry;
  logic [15:0]   stat_evict;
`endif

  sched_partial_dispatcher #(
    .W(W), .DEPTH(DEPTH), .TICK_PERIOD(4), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_action(cfg_action),
    .in_valid(in_valid), .in_task(in_task), .in_ready(in_ready),
    .sch_wr(sch_wr), .sch_task(sch_task), .sch_action(sch_action),
    .sch_subtract_en(sch_subtract_en), .sch_busy_ready(sch_busy_ready),
    .sch_v_exch(sch_v_exch), .sch_v_active(sch_v_active), .sch_task_exch(sch_task_exch),
    .evict_valid(evict_valid), .evict_task(evict_task), .evict_err(evict_err),
    .evict_ready(evict_ready), .fifo_count(fifo_count)
`ifdef DISPATCH_STATS_EN
    , .stat_issued(stat_issued), .stat_retry(stat_retry), .stat_evict(stat_evict)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Scheduler model controls: result presented when busy drops.
  logic          m_exch   = 1'b0;
  logic          m_active = 1'b0;
  logic [TW-1:0] m_texch  = '0;

  logic [TW-1:0] wr_q[$];
  int            coincide   = 0;
  bit            evict_seen = 1'b0;

  typedef struct {
    logic [TW-1:0] word;
    logic          exch;
    logic          active;
    logic [TW-1:0] texch;
    int            exp_wr;
    int            exp_ev;
    logic [TW-1:0] exp_evtask;
    logic          exp_err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [TW-1:0] w);
    in_valid = 1'b1;
    in_task  = w;
    tick();
    in_valid = 1'b0;
  endtask

  // Scheduler model: busy for two cycles after each write, then result.
  initial begin
    sch_busy_ready = 1'b0;
    sch_v_exch     = 1'b0;
    sch_v_active   = 1'b0;
    sch_task_exch  = '0;
    forever begin
      tick();
      if (sch_wr) begin
        sch_busy_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sch_busy_ready = 1'b0;
        sch_v_exch     = m_exch;
        sch_v_active   = m_active;
        sch_task_exch  = m_texch;
      end
    end
  end

  // Write / evict monitor.
  initial begin
    forever begin
      tick();
      if (sch_wr) begin
        wr_q.push_back(sch_task);
        if (sch_subtract_en) coincide++;
      end
      if (evict_valid) evict_seen = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   ev_n;
    int   same_n;
    logic [TW-1:0] ev_task;
    logic ev_err;
    bit   got;

    vecs[0] = '{58'h1,  1'b0, 1'b0, 58'h0,  1, 0, 58'h0,  1'b0};
    vecs[1] = '{58'h2,  1'b0, 1'b0, 58'h0,  1, 0, 58'h0,  1'b0};
    vecs[2] = '{58'h10, 1'b1, 1'b0, 58'h5A, 1, 1, 58'h5A, 1'b0};
    vecs[3] = '{58'h20, 1'b1, 1'b1, 58'h0,  4, 1, 58'h20, 1'b1};
    vecs[4] = '{58'h33, 1'b1, 1'b0, 58'h7,  1, 1, 58'h7,  1'b0};
    vecs[5] = '{58'h3FF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 58'h0, 4, 1, 58'h3FF_FFFF_FFFF_FFFF, 1'b1};

    rst = 1'b1; en = 1'b0; cfg_action = 1'b0; in_valid = 1'b0; in_task = '0;
    evict_ready = 1'b0;
    repeat (3) tick();
    check("rst_sch_wr", 64'(sch_wr), 64'd0);
    check("rst_sch_task", 64'(sch_task), 64'd0);
    check("rst_subtract", 64'(sch_subtract_en), 64'd0);
    check("rst_evict_valid", 64'(evict_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_sch_action", 64'(sch_action), 64'd0);
    rst = 1'b0;
    tick();

    // Three buffered tasks issued in order.
    push(58'h1); push(58'h2); push(58'h3);
    check("three_count", 64'(fifo_count), 64'd3);
    wr_q.delete();
    evict_seen = 1'b0;
    en = 1'b1;
    repeat (30) tick();
    check("three_n", 64'(wr_q.size()), 64'd3);
    if (wr_q.size() == 3) begin
      check("three_w0", 64'(wr_q[0]), 64'h1);
      check("three_w1", 64'(wr_q[1]), 64'h2);
      check("three_w2", 64'(wr_q[2]), 64'h3);
    end
    check("three_drained", 64'(fifo_count), 64'd0);
    check("three_no_evict", 64'(evict_seen), 64'd0);

    // Fill past full with dispatch disabled.
    en = 1'b0;
    repeat (2) tick();
    wr_q.delete();
    for (int i = 0; i <= DEPTH; i++) push(TW'(32'h100 + i));
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_count", 64'(fifo_count), 64'(DEPTH));
    en = 1'b1;
    repeat (60) tick();
    check("full_drain_n", 64'(wr_q.size()), 64'(DEPTH));
    if (wr_q.size() == DEPTH) begin
      check("full_first", 64'(wr_q[0]), 64'h100);
      check("full_last", 64'(wr_q[DEPTH-1]), 64'h107);
    end
    check("full_in_ready_back", 64'(in_ready), 64'd1);

    // Vector table: one task per vector with scheduler result and expected outcome.
    for (int v = 0; v < 6; v++) begin
      m_exch = vecs[v].exch; m_active = vecs[v].active; m_texch = vecs[v].texch;
      wr_q.delete();
      ev_n = 0; ev_task = '0; ev_err = 1'b0;
      en = 1'b1;
      push(vecs[v].word);
      for (int c = 0; c < 40; c++) begin
        if (evict_valid && !evict_ready) begin
          ev_n++;
          ev_task = evict_task;
          ev_err  = evict_err;
          evict_ready = 1'b1;
        end else begin
          evict_ready = 1'b0;
        end
        tick();
      end
      evict_ready = 1'b0;
      same_n = 0;
      foreach (wr_q[k]) if (wr_q[k] == vecs[v].word) same_n++;
      check($sformatf("vec%0d_wr_n", v), 64'(wr_q.size()), 64'(vecs[v].exp_wr));
      check($sformatf("vec%0d_wr_word", v), 64'(same_n), 64'(vecs[v].exp_wr));
      check($sformatf("vec%0d_ev_n", v), 64'(ev_n), 64'(vecs[v].exp_ev));
      if (vecs[v].exp_ev != 0) begin
        check($sformatf("vec%0d_ev_task", v), 64'(ev_task), 64'(vecs[v].exp_evtask));
        check($sformatf("vec%0d_ev_err", v), 64'(ev_err), 64'(vecs[v].exp_err));
      end
    end

    // Evict back-pressure: word held stable, next task waits for acceptance.
    en = 1'b0;
    m_exch = 1'b1; m_active = 1'b0; m_texch = 58'h5A;
    push(58'hAB); push(58'hCD);
    wr_q.delete();
    en = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      if (evict_valid) got = 1'b1;
    end
    check("stall_evict_seen", 64'(got), 64'd1);
    m_exch = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall_valid_%0d", i), 64'(evict_valid), 64'd1);
      check($sformatf("stall_task_%0d", i), 64'(evict_task), 64'h5A);
      check($sformatf("stall_err_%0d", i), 64'(evict_err), 64'd0);
      check($sformatf("stall_wr_n_%0d", i), 64'(wr_q.size()), 64'd1);
      if (i == 3) evict_ready = 1'b1;
      else tick();
    end
    tick();
    evict_ready = 1'b0;
    check("stall_released", 64'(evict_valid), 64'd0);
    repeat (20) tick();
    check("stall_next_n", 64'(wr_q.size()), 64'd2);
    if (wr_q.size() == 2) check("stall_next_word", 64'(wr_q[1]), 64'hCD);

    // Tick aligned with an ISSUE cycle is delayed by exactly one cycle.
    en = 1'b0;
    push(58'h77);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (sch_subtract_en) got = 1'b1;
    end
    check("tick_seen", 64'(got), 64'd1);
    repeat (2) tick();
    @(posedge clk);
    #1;
    en = 1'b1;
    tick();
    check("tick_issue_wr", 64'(sch_wr), 64'd1);
    check("tick_issue_sub", 64'(sch_subtract_en), 64'd0);
    tick();
    check("tick_delay_wr", 64'(sch_wr), 64'd0);
    check("tick_delay_sub", 64'(sch_subtract_en), 64'd1);
    tick();
    check("tick_gap_a", 64'(sch_subtract_en), 64'd0);
    tick();
    check("tick_gap_b", 64'(sch_subtract_en), 64'd0);
    tick();
    check("tick_next", 64'(sch_subtract_en), 64'd1);
    repeat (3) begin
      tick();
      check("tick_gap_c", 64'(sch_subtract_en), 64'd0);
    end
    tick();
    check("tick_next2", 64'(sch_subtract_en), 64'd1);

    // Reset during WAIT_LO discards the in-flight task and FIFO.
    en = 1'b0;
    repeat (4) tick();
    m_exch = 1'b0;
    push(58'h11); push(58'h22); push(58'h33);
    en = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (sch_wr) got = 1'b1;
    end
    check("rstmid_issue_seen", 64'(got), 64'd1);
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("rstmid_sch_wr", 64'(sch_wr), 64'd0);
    check("rstmid_sch_task", 64'(sch_task), 64'd0);
    check("rstmid_evict", 64'(evict_valid), 64'd0);
    check("rstmid_sub", 64'(sch_subtract_en), 64'd0);
    check("rstmid_in_ready", 64'(in_ready), 64'd1);
    check("rstmid_count", 64'(fifo_count), 64'd0);
    en = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    check("rstmid_after_count", 64'(fifo_count), 64'd0);
    check("rstmid_after_ready", 64'(in_ready), 64'd1);

    check("no_wr_sub_overlap", 64'(coincide), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
